// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// MEM stage of the pipeline: issues data-memory requests for loads and
// stores, holds the pipeline while the memory handshake is outstanding, and
// owns the MEM/WB pipeline register.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   MEM_in*                    instruction fields presented by EX/MEM
//   DM_req/we/addr/be/wdata    request channel to data memory
//   DM_gnt                     request accepted this cycle
//   DM_rvalid/DM_rdata         read response (only honoured in WAIT)
//   MEM_outSTALL               upstream must hold MEM_in* stable while high
//   MEM_outMISALIGN            one-cycle pulse after a misaligned access
//   WB_out*                    MEM/WB register contents
//   o_dbg_state                current FSM state (IDLE=0, REQ=1, WAIT=2)
//
// Handshake: a request is transferred on a rising edge where DM_req and
// DM_gnt are both high; until then DM_addr/we/be/wdata stay stable. A read
// response is transferred on a rising edge where the FSM is in WAIT and
// DM_rvalid is high; DM_rvalid in any other state is ignored.
// -----------------------------------------------------------------------------
module mem_stage_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_invalid,
  input  logic        MEM_inMEMREAD,
  input  logic        MEM_inMEMWRITE,
  input  logic [1:0]  MEM_inSIZE,
  input  logic        MEM_insignLW,
  input  logic [31:0] MEM_inaddANS,
  input  logic [31:0] MEM_inSTOREDATA,
  input  logic        MEM_inMEMTOREG,
  input  logic        MEM_inLINKSIG,
  input  logic [31:0] MEM_inALINKPC,
  output logic        DM_req,
  output logic        DM_we,
  output logic [31:0] DM_addr,
  output logic [3:0]  DM_be,
  output logic [31:0] DM_wdata,
  input  logic        DM_gnt,
  input  logic        DM_rvalid,
  input  logic [31:0] DM_rdata,
  output logic        MEM_outSTALL,
  output logic        MEM_outMISALIGN,
  output logic        WB_outvalid,
  output logic [31:0] WB_outfromplw,
  output logic [1:0]  WB_outLASTSIZE,
  output logic        WB_outsignLW,
  output logic [31:0] WB_outpaddANS,
  output logic        WB_outMEMTOREG,
  output logic [31:0] WB_outALINKPC,
  output logic        WB_outLINKSIG,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t      r_state, w_next;
  logic        w_is_mem, w_is_load, w_is_store, w_is_half, w_is_byte;
  logic        w_misalign, w_aligned_op;
  logic        w_req, w_stall, w_retire;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_data;

  logic        r_misalign, r_wb_valid, r_wb_signlw, r_wb_memtoreg, r_wb_linksig;
  logic [31:0] r_wb_fromplw, r_wb_paddans, r_wb_alinkpc;
  logic [1:0]  r_wb_lastsize;

  // READ wins when both READ and WRITE are set.
  assign w_is_mem     = MEM_invalid & (MEM_inMEMREAD | MEM_inMEMWRITE);
  assign w_is_load    = MEM_inMEMREAD;
  assign w_is_store   = MEM_inMEMWRITE & ~MEM_inMEMREAD;
  assign w_is_half    = (MEM_inSIZE == 2'b01);
  assign w_is_byte    = (MEM_inSIZE == 2'b10);
  // Size 11 is handled as a word access everywhere.
  assign w_misalign   = w_is_mem &
                        ((w_is_half & MEM_inaddANS[0]) |
                         (~w_is_half & ~w_is_byte & (MEM_inaddANS[1:0] != 2'b00)));
  assign w_aligned_op = w_is_mem & ~w_misalign;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = MEM_inSTOREDATA;
    if (w_is_half) begin
      w_be    = MEM_inaddANS[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{MEM_inSTOREDATA[15:0]}};
    end else if (w_is_byte) begin
      w_be    = 4'b0001 << MEM_inaddANS[1:0];
      w_wdata = {4{MEM_inSTOREDATA[7:0]}};
    end
  end

  // Lane shift only; sign/size extraction happens in WB.
  assign w_load_data = DM_rdata >> {MEM_inaddANS[1:0], 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_req    = 1'b0;
    w_stall  = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      S_IDLE, S_REQ: begin
        if (r_state == S_REQ || w_aligned_op) begin
          w_req = 1'b1;
          if (!DM_gnt) begin
            w_next  = S_REQ;
            w_stall = 1'b1;
          end else if (w_is_load) begin
            w_next  = S_WAIT;
            w_stall = 1'b1;
          end else begin
            w_next   = S_IDLE;
            w_retire = 1'b1;
          end
        end else if (MEM_invalid && !w_is_mem) begin
          w_retire = 1'b1;
        end
      end
      S_WAIT: begin
        if (DM_rvalid) begin
          w_next   = S_IDLE;
          w_retire = 1'b1;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Reset gates the combinational outputs so they drop the moment rst_n falls.
  assign DM_req       = w_req & rst_n;
  assign DM_we        = DM_req & w_is_store;
  assign DM_addr      = DM_req ? {MEM_inaddANS[31:2], 2'b00} : 32'd0;
  assign DM_be        = DM_req ? w_be : 4'd0;
  assign DM_wdata     = DM_req ? w_wdata : 32'd0;
  assign MEM_outSTALL = w_stall & rst_n;
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign    <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_fromplw  <= 32'd0;
      r_wb_lastsize <= 2'd0;
      r_wb_signlw   <= 1'b0;
      r_wb_paddans  <= 32'd0;
      r_wb_memtoreg <= 1'b0;
      r_wb_alinkpc  <= 32'd0;
      r_wb_linksig  <= 1'b0;
    end else begin
      r_misalign <= (r_state == S_IDLE) & w_misalign;
      if (w_retire) begin
        r_wb_valid    <= 1'b1;
        // Only a retirement out of WAIT is a load with data.
        r_wb_fromplw  <= (r_state == S_WAIT) ? w_load_data : 32'd0;
        r_wb_lastsize <= MEM_inSIZE;
        r_wb_signlw   <= MEM_insignLW;
        r_wb_paddans  <= MEM_inaddANS;
        r_wb_memtoreg <= MEM_inMEMTOREG;
        r_wb_alinkpc  <= MEM_inALINKPC;
        r_wb_linksig  <= MEM_inLINKSIG;
      end else begin
        r_wb_valid    <= 1'b0;
        r_wb_memtoreg <= 1'b0;
        r_wb_linksig  <= 1'b0;
      end
    end
  end

  assign MEM_outMISALIGN = r_misalign;
  assign WB_outvalid     = r_wb_valid;
  assign WB_outfromplw   = r_wb_fromplw;
  assign WB_outLASTSIZE  = r_wb_lastsize;
  assign WB_outsignLW    = r_wb_signlw;
  assign WB_outpaddANS   = r_wb_paddans;
  assign WB_outMEMTOREG  = r_wb_memtoreg;
  assign WB_outALINKPC   = r_wb_alinkpc;
  assign WB_outLINKSIG   = r_wb_linksig;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Drives instructions into mem_stage_lsu, plays the data-memory side with
// chosen grant/response delays, checks the request channel and stall every
// cycle, and checks each MEM/WB record against an expected queue.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

  localparam int WBW = 101;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        MEM_invalid, MEM_inMEMREAD, MEM_inMEMWRITE, MEM_insignLW;
  logic [1:0]  MEM_inSIZE;
  logic [31:0] MEM_inaddANS, MEM_inSTOREDATA, MEM_inALINKPC;
  logic        MEM_inMEMTOREG, MEM_inLINKSIG;
  logic        DM_req, DM_we, DM_gnt, DM_rvalid;
  logic [31:0] DM_addr, DM_wdata, DM_rdata;
  logic [3:0]  DM_be;
  logic        MEM_outSTALL, MEM_outMISALIGN;
  logic        WB_outvalid, WB_outsignLW, WB_outMEMTOREG, WB_outLINKSIG;
  logic [31:0] WB_outfromplw, WB_outpaddANS, WB_outALINKPC;
  logic [1:0]  WB_outLASTSIZE, o_dbg_state;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_invalid(MEM_invalid), .MEM_inMEMREAD(MEM_inMEMREAD),
    .MEM_inMEMWRITE(MEM_inMEMWRITE), .MEM_inSIZE(MEM_inSIZE),
    .MEM_insignLW(MEM_insignLW), .MEM_inaddANS(MEM_inaddANS),
    .MEM_inSTOREDATA(MEM_inSTOREDATA), .MEM_inMEMTOREG(MEM_inMEMTOREG),
    .MEM_inLINKSIG(MEM_inLINKSIG), .MEM_inALINKPC(MEM_inALINKPC),
    .DM_req(DM_req), .DM_we(DM_we), .DM_addr(DM_addr), .DM_be(DM_be),
    .DM_wdata(DM_wdata), .DM_gnt(DM_gnt), .DM_rvalid(DM_rvalid),
    .DM_rdata(DM_rdata), .MEM_outSTALL(MEM_outSTALL),
    .MEM_outMISALIGN(MEM_outMISALIGN), .WB_outvalid(WB_outvalid),
    .WB_outfromplw(WB_outfromplw), .WB_outLASTSIZE(WB_outLASTSIZE),
    .WB_outsignLW(WB_outsignLW), .WB_outpaddANS(WB_outpaddANS),
    .WB_outMEMTOREG(WB_outMEMTOREG), .WB_outALINKPC(WB_outALINKPC),
    .WB_outLINKSIG(WB_outLINKSIG), .o_dbg_state(o_dbg_state)
  );

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        sign;
    logic [31:0] addr, sd;
    logic        m2r, link;
    logic [31:0] pc;
    int          gnt_dly, rv_dly;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wd, rdx;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [WBW-1:0] exp_q[$];
  bit exp_ret = 0;
  bit exp_mis = 0;
  bit mon_en  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'b01: return a[1] ? 4'b1100 : 4'b0011;
      2'b10: case (a[1:0])
               2'd0: return 4'b0001;
               2'd1: return 4'b0010;
               2'd2: return 4'b0100;
               default: return 4'b1000;
             endcase
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b01: return {d[15:0], d[15:0]};
      2'b10: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b10) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] m_ld(input logic [31:0] a, input logic [31:0] r);
    case (a[1:0])
      2'd0: return r;
      2'd1: return {8'h0, r[31:8]};
      2'd2: return {16'h0, r[31:16]};
      default: return {24'h0, r[31:24]};
    endcase
  endfunction

  // monitor: one check per edge, sampled 2 time units after the rising edge
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      chk("wb_valid", {WB_outvalid, WB_outMEMTOREG & ~exp_ret, WB_outLINKSIG & ~exp_ret},
          {exp_ret, 1'b0, 1'b0});
      if (WB_outvalid && exp_ret && exp_q.size() > 0) begin
        chk("wb_rec", {WB_outfromplw, WB_outLASTSIZE, WB_outsignLW, WB_outpaddANS,
                       WB_outMEMTOREG, WB_outALINKPC, WB_outLINKSIG}, exp_q.pop_front());
      end
      chk("misalign", MEM_outMISALIGN, exp_mis);
      exp_ret = 0;
      exp_mis = 0;
    end
  end

  task automatic go_idle();
    MEM_invalid = 0; MEM_inMEMREAD = 0; MEM_inMEMWRITE = 0;
    DM_gnt = 0; DM_rvalid = 0;
  endtask

  task automatic push_ret(input vec_t v);
    logic [31:0] f;
    f = v.rd ? v.rdx : 32'd0;
    exp_q.push_back({f, v.sz, v.sign, v.addr, v.m2r, v.pc, v.link});
    exp_ret = 1;
  endtask

  task automatic chk_req(input vec_t v, input logic stall);
    chk("dm_req", DM_req, 1'b1);
    chk("dm_we", DM_we, v.wr & ~v.rd);
    chk("dm_addr", DM_addr, {v.addr[31:2], 2'b00});
    chk("dm_be", DM_be, v.be);
    chk("dm_wdata", DM_wdata, v.wd);
    chk("stall_req", MEM_outSTALL, stall);
  endtask

  // driver: one instruction from entry to retirement
  task automatic do_op(input vec_t v);
    logic is_mem;
    is_mem = v.rd | v.wr;
    @(negedge clk);
    MEM_invalid = 1; MEM_inMEMREAD = v.rd; MEM_inMEMWRITE = v.wr;
    MEM_inSIZE = v.sz; MEM_insignLW = v.sign; MEM_inaddANS = v.addr;
    MEM_inSTOREDATA = v.sd; MEM_inMEMTOREG = v.m2r; MEM_inLINKSIG = v.link;
    MEM_inALINKPC = v.pc;
    DM_gnt = (v.gnt_dly == 0); DM_rvalid = 0; DM_rdata = $urandom;
    #1;
    if (!is_mem || m_mis(v.sz, v.addr)) begin
      chk("req_off", DM_req, 1'b0);
      chk("stall_off", MEM_outSTALL, 1'b0);
      if (is_mem) exp_mis = 1;
      else push_ret(v);
    end else begin
      for (int c = 0; c <= v.gnt_dly; c++) begin
        if (c > 0) begin
          @(negedge clk);
          DM_gnt = (c == v.gnt_dly);
          DM_rvalid = $urandom_range(0, 1);
          #1;
        end
        chk_req(v, (c < v.gnt_dly) || v.rd);
      end
      if (!v.rd) push_ret(v);
      else begin
        for (int c = 0; c <= v.rv_dly; c++) begin
          @(negedge clk);
          DM_gnt = 0;
          DM_rvalid = (c == v.rv_dly);
          DM_rdata = (c == v.rv_dly) ? v.rdata : $urandom;
          #1;
          chk("req_wait", DM_req, 1'b0);
          chk("stall_wait", MEM_outSTALL, (c < v.rv_dly));
        end
        push_ret(v);
      end
    end
    @(negedge clk);
    go_idle();
  endtask

  vec_t tbl[13];
  vec_t rv;

  initial begin
    //          rd wr  sz    sg addr         sd            m2r lk pc            g  r  rdata         be       wd            rdx
    tbl[0]  = '{1, 0, 2'b10, 1, 32'h103, 32'h0,        1, 0, 32'h1000, 0, 0, 32'h80AABBCC, 4'b1000, 32'h0,        32'h00000080};
    tbl[1]  = '{0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 0, 0, 32'h1004, 3, 0, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0};
    tbl[2]  = '{1, 0, 2'b00, 0, 32'h101, 32'h0,        1, 0, 32'h1008, 0, 0, 32'h0,        4'b1111, 32'h0,        32'h0};
    tbl[3]  = '{0, 0, 2'b00, 0, 32'h55,  32'h0,        0, 1, 32'h400008, 0, 0, 32'h0,      4'b1111, 32'h0,        32'h0};
    tbl[4]  = '{1, 0, 2'b00, 0, 32'h200, 32'h0,        1, 0, 32'h1010, 1, 2, 32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF};
    tbl[5]  = '{1, 0, 2'b01, 1, 32'h0A,  32'h0,        1, 0, 32'h1014, 0, 1, 32'h12345678, 4'b1100, 32'h0,        32'h00001234};
    tbl[6]  = '{0, 1, 2'b10, 0, 32'h11,  32'hFFFFFF5A, 0, 0, 32'h1018, 0, 0, 32'h0,        4'b0010, 32'h5A5A5A5A, 32'h0};
    tbl[7]  = '{0, 1, 2'b00, 0, 32'h40,  32'hCAFEF00D, 0, 0, 32'h101C, 0, 0, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0};
    tbl[8]  = '{0, 1, 2'b01, 0, 32'h33,  32'h77,       0, 0, 32'h1020, 0, 0, 32'h0,        4'b1111, 32'h0,        32'h0};
    tbl[9]  = '{1, 0, 2'b11, 0, 32'h80,  32'h0,        1, 0, 32'h1024, 0, 0, 32'h01020304, 4'b1111, 32'h0,        32'h01020304};
    tbl[10] = '{1, 1, 2'b00, 0, 32'h8,   32'h11111111, 1, 0, 32'h1028, 2, 0, 32'h55AA55AA, 4'b1111, 32'h11111111, 32'h55AA55AA};
    tbl[11] = '{1, 0, 2'b10, 0, 32'h102, 32'h0,        1, 0, 32'h102C, 0, 0, 32'h80AABBCC, 4'b0100, 32'h0,        32'h000080AA};
    tbl[12] = '{1, 0, 2'b11, 0, 32'h82,  32'h0,        1, 0, 32'h1030, 0, 0, 32'h0,        4'b1111, 32'h0,        32'h0};

    go_idle();
    MEM_inSIZE = 0; MEM_insignLW = 0; MEM_inaddANS = 0; MEM_inSTOREDATA = 0;
    MEM_inMEMTOREG = 0; MEM_inLINKSIG = 0; MEM_inALINKPC = 0; DM_rdata = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_state", o_dbg_state, 2'd0);
    chk("rst_outs", {DM_req, MEM_outSTALL, MEM_outMISALIGN, WB_outvalid, WB_outMEMTOREG,
                     WB_outLINKSIG, WB_outsignLW}, 7'd0);
    chk("rst_wb", {WB_outfromplw, WB_outpaddANS, WB_outALINKPC, WB_outLASTSIZE}, 98'd0);
    rst_n = 1;
    mon_en = 1;

    for (int i = 0; i < 13; i++) do_op(tbl[i]);

    // back-to-back random mix checked against the model
    for (int i = 0; i < 30; i++) begin
      rv.rd = $urandom_range(0, 1); rv.wr = $urandom_range(0, 1);
      rv.sz = $urandom_range(0, 3); rv.sign = $urandom_range(0, 1);
      rv.addr = $urandom; rv.sd = $urandom;
      rv.m2r = $urandom_range(0, 1); rv.link = $urandom_range(0, 1); rv.pc = $urandom;
      rv.gnt_dly = $urandom_range(0, 2); rv.rv_dly = $urandom_range(0, 2);
      rv.rdata = $urandom;
      rv.be = m_be(rv.sz, rv.addr);
      rv.wd = m_wd(rv.sz, rv.sd);
      rv.rdx = m_ld(rv.addr, rv.rdata);
      do_op(rv);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    // reset while waiting for a read response
    repeat (2) @(negedge clk);
    chk("q_drained", exp_q.size(), 0);
    mon_en = 0;
    @(negedge clk);
    MEM_invalid = 1; MEM_inMEMREAD = 1; MEM_inMEMWRITE = 0; MEM_inSIZE = 2'b00;
    MEM_inaddANS = 32'h300; MEM_inMEMTOREG = 1; MEM_inLINKSIG = 1; DM_gnt = 1;
    @(negedge clk);
    DM_gnt = 0;
    #1;
    chk("in_wait", o_dbg_state, 2'd2);
    rst_n = 0;
    #1;
    chk("rst_mid_state", o_dbg_state, 2'd0);
    chk("rst_mid_outs", {DM_req, MEM_outSTALL, MEM_outMISALIGN, WB_outvalid,
                         WB_outMEMTOREG, WB_outLINKSIG}, 6'd0);
    chk("rst_mid_wb", {WB_outfromplw, WB_outpaddANS, WB_outALINKPC}, 96'd0);
    @(negedge clk);
    rst_n = 1;
    go_idle();
    @(negedge clk);
    DM_rvalid = 1; DM_rdata = 32'hFEEDFACE;
    @(negedge clk);
    DM_rvalid = 0;
    #1;
    chk("late_rvalid_state", o_dbg_state, 2'd0);
    chk("late_rvalid_wb", {WB_outvalid, WB_outfromplw, DM_req, MEM_outSTALL}, 35'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
